// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_mem_pkg
//  Purpose  : Shared access-size codes, M-stage alignment FSM state encoding
//             and the request legality rule used by the memory-side datapath.
//  Revision : 1.0 - initial release
// ============================================================================
package mips_mem_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   // Illegal size code, or halfword/word not naturally aligned.
   function automatic logic req_legal(input logic [1:0] size, input logic [1:0] addr_lo);
      logic ok;
      ok = 1'b1;
      if (size == 2'b11)                        ok = 1'b0;
      if (size == SIZE_HALF && addr_lo[0])      ok = 1'b0;
      if (size == SIZE_WORD && addr_lo != 2'b00) ok = 1'b0;
      return ok;
   endfunction

endpackage
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// ============================================================================
//  Module   : load_extend
//  Purpose  : Selects the addressed byte/half lane of a little-endian read
//             word and sign- or zero-extends it to 32 bits. Combinational.
//  Ports    : i_rdata     - 32-bit word read from memory
//             i_addr_lo   - byte address bits [1:0]
//             i_size      - 00 byte, 01 half, 10 word
//             i_unsigned  - 1 = zero-extend, 0 = sign-extend
//             o_result    - extended load value
//  Revision : 1.0 - initial release
// ============================================================================
module load_extend
   import mips_mem_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [1:0]  i_addr_lo,
   input  logic [1:0]  i_size,
   input  logic        i_unsigned,
   output logic [31:0] o_result
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte   = i_rdata[{i_addr_lo, 3'b000} +: 8];
      w_half   = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];
      o_result = i_rdata;
      case (i_size)
         SIZE_BYTE: o_result = {{24{w_byte[7]  & ~i_unsigned}}, w_byte};
         SIZE_HALF: o_result = {{16{w_half[15] & ~i_unsigned}}, w_half};
         default:   o_result = i_rdata;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mem_align_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mem_align_unit
//  Purpose  : M-stage load/store alignment. Narrows store data into byte
//             lanes with byte enables, extends load lanes back to 32 bits,
//             and runs one valid/ready data-memory transaction per
//             instruction while stalling the pipeline.
//  Ports    : clk, reset (sync, active-high)
//             req_*      - M-stage memory instruction
//             stall      - freeze pipeline registers
//             rdata_out / rdata_valid - extended load result, 1-cycle valid
//             addr_err   - misaligned / illegal size (1 cycle)
//             bus_err    - dm_ready timeout abort (1 cycle)
//             dm_*       - data-memory request/response
//  Params   : TIMEOUT - dm_ready wait limit in cycles, 0 = wait forever
//             CNT_W   - wait counter width, TIMEOUT must fit in CNT_W bits
//  Revision : 1.0 - initial release
// ============================================================================
module mem_align_unit
   import mips_mem_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CNT_W   = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic [31:0] rdata_out,
   output logic        rdata_valid,
   output logic        addr_err,
   output logic        bus_err,
   output logic        dm_req,
   output logic        dm_we,
   output logic [3:0]  dm_be,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   input  logic        dm_ready,
   input  logic [31:0] dm_rdata
);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               dm_req_q, dm_req_d, dm_we_q, dm_we_d;
   logic [3:0]         dm_be_q, dm_be_d;
   logic [31:0]        dm_addr_q, dm_addr_d, dm_wdata_q, dm_wdata_d;
   logic [1:0]         size_q, size_d, addr_lo_q, addr_lo_d;
   logic               uns_q, uns_d;
   logic [31:0]        rdata_out_q, rdata_out_d;
   logic               rdata_valid_q, rdata_valid_d;
   logic               addr_err_q, addr_err_d, bus_err_q, bus_err_d;

   logic               w_legal;
   logic [3:0]         w_be;
   logic [31:0]        w_wdata;
   logic [31:0]        w_ext;

   assign w_legal = req_legal(req_size, req_addr[1:0]);

   // Store lanes are replicated so the addressed lane carries the data
   // regardless of offset; loads enable the full word and write nothing.
   always_comb begin
      w_be    = 4'b1111;
      w_wdata = '0;
      if (req_we) begin
         case (req_size)
            SIZE_BYTE: begin
               w_be    = 4'b0001 << req_addr[1:0];
               w_wdata = {4{req_wdata[7:0]}};
            end
            SIZE_HALF: begin
               w_be    = req_addr[1] ? 4'b1100 : 4'b0011;
               w_wdata = {2{req_wdata[15:0]}};
            end
            default:   w_wdata = req_wdata;
         endcase
      end
   end

   load_extend u_load_extend (
      .i_rdata    (dm_rdata),
      .i_addr_lo  (addr_lo_q),
      .i_size     (size_q),
      .i_unsigned (uns_q),
      .o_result   (w_ext)
   );

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      dm_req_d      = dm_req_q;
      dm_we_d       = dm_we_q;
      dm_be_d       = dm_be_q;
      dm_addr_d     = dm_addr_q;
      dm_wdata_d    = dm_wdata_q;
      size_d        = size_q;
      addr_lo_d     = addr_lo_q;
      uns_d         = uns_q;
      rdata_out_d   = rdata_out_q;
      rdata_valid_d = 1'b0;
      addr_err_d    = 1'b0;
      bus_err_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               if (w_legal) begin
                  state_d    = ST_BUSY;
                  cnt_d      = '0;
                  dm_req_d   = 1'b1;
                  dm_we_d    = req_we;
                  dm_be_d    = w_be;
                  dm_addr_d  = {req_addr[31:2], 2'b00};
                  dm_wdata_d = w_wdata;
                  size_d     = req_size;
                  addr_lo_d  = req_addr[1:0];
                  uns_d      = req_unsigned;
               end else begin
                  addr_err_d = 1'b1;
               end
            end
         end
         ST_BUSY: begin
            if (dm_ready) begin
               state_d  = ST_DONE;
               dm_req_d = 1'b0;
               if (!dm_we_q) begin
                  rdata_out_d   = w_ext;
                  rdata_valid_d = 1'b1;
               end
            end else begin
               // The abort fires on the edge where the count of ready-low
               // BUSY cycles reaches TIMEOUT.
               cnt_d = cnt_q + 1'b1;
               if (TIMEOUT != 0 && cnt_d == CNT_W'(TIMEOUT)) begin
                  state_d     = ST_DONE;
                  dm_req_d    = 1'b0;
                  bus_err_d   = 1'b1;
                  rdata_out_d = '0;
               end
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         dm_req_q      <= 1'b0;
         dm_we_q       <= 1'b0;
         dm_be_q       <= '0;
         dm_addr_q     <= '0;
         dm_wdata_q    <= '0;
         size_q        <= '0;
         addr_lo_q     <= '0;
         uns_q         <= 1'b0;
         rdata_out_q   <= '0;
         rdata_valid_q <= 1'b0;
         addr_err_q    <= 1'b0;
         bus_err_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         dm_req_q      <= dm_req_d;
         dm_we_q       <= dm_we_d;
         dm_be_q       <= dm_be_d;
         dm_addr_q     <= dm_addr_d;
         dm_wdata_q    <= dm_wdata_d;
         size_q        <= size_d;
         addr_lo_q     <= addr_lo_d;
         uns_q         <= uns_d;
         rdata_out_q   <= rdata_out_d;
         rdata_valid_q <= rdata_valid_d;
         addr_err_q    <= addr_err_d;
         bus_err_q     <= bus_err_d;
      end
   end

   // Stall asserts in the request cycle itself so the pipeline holds the
   // instruction while it is captured; DONE releases it.
   assign stall       = (state_q == ST_IDLE && req_valid && w_legal) || (state_q == ST_BUSY);
   assign dm_req      = dm_req_q;
   assign dm_we       = dm_we_q;
   assign dm_be       = dm_be_q;
   assign dm_addr     = dm_addr_q;
   assign dm_wdata    = dm_wdata_q;
   assign rdata_out   = rdata_out_q;
   assign rdata_valid = rdata_valid_q;
   assign addr_err    = addr_err_q;
   assign bus_err     = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_align_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_align_unit
//  Purpose  : Self-checking bench for mem_align_unit against a behavioural
//             model of lane mapping, extension and transaction timing.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_align_unit;
   import mips_mem_pkg::*;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, req_valid, req_we, req_unsigned, dm_ready;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata, dm_rdata;
   logic        stall, rdata_valid, addr_err, bus_err, dm_req, dm_we;
   logic [31:0] rdata_out, dm_addr, dm_wdata;
   logic [3:0]  dm_be;

   // Second instance with a short timeout, sharing the request fields.
   logic        req_valid_t, dm_ready_t;
   logic        t_stall, t_rdata_valid, t_addr_err, t_bus_err, t_dm_req, t_dm_we;
   logic [31:0] t_rdata_out, t_dm_addr, t_dm_wdata;
   logic [3:0]  t_dm_be;

   int total = 0;
   int bad   = 0;

   mem_align_unit dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .stall(stall), .rdata_out(rdata_out),
      .rdata_valid(rdata_valid), .addr_err(addr_err), .bus_err(bus_err),
      .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_ready(dm_ready), .dm_rdata(dm_rdata)
   );

   mem_align_unit #(.TIMEOUT(3), .CNT_W(8)) dut_t (
      .clk(clk), .reset(reset), .req_valid(req_valid_t), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .stall(t_stall), .rdata_out(t_rdata_out),
      .rdata_valid(t_rdata_valid), .addr_err(t_addr_err), .bus_err(t_bus_err),
      .dm_req(t_dm_req), .dm_we(t_dm_we), .dm_be(t_dm_be), .dm_addr(t_dm_addr),
      .dm_wdata(t_dm_wdata), .dm_ready(dm_ready_t), .dm_rdata(dm_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int nbytes(input logic [1:0] sz);
      return (sz == SIZE_BYTE) ? 1 : (sz == SIZE_HALF) ? 2 : 4;
   endfunction

   function automatic logic m_legal(input logic [1:0] sz, input logic [31:0] a);
      if (sz == 2'b11) return 1'b0;
      return (a % nbytes(sz)) == 0;
   endfunction

   // A byte lane is enabled when it lies in the same naturally aligned
   // n-byte chunk as the access address.
   function automatic logic [3:0] m_be(input logic we, input logic [1:0] sz, input logic [31:0] a);
      logic [3:0] be;
      int n = nbytes(sz);
      int off = int'(a[1:0]);
      if (!we) return 4'hF;
      for (int i = 0; i < 4; i++) be[i] = ((i / n) == (off / n));
      return be;
   endfunction

   function automatic logic [31:0] m_wdata(input logic we, input logic [1:0] sz, input logic [31:0] d);
      logic [31:0] w;
      int n = nbytes(sz);
      if (!we) return 32'h0;
      for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % n) +: 8];
      return w;
   endfunction

   function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns,
                                          input logic [31:0] a, input logic [31:0] rd);
      int n = nbytes(sz);
      longint v = longint'(rd) >> (8 * int'(a[1:0]));
      longint span = longint'(1) << (8 * n);
      if (n == 4) return rd;
      v = v % span;
      if (!uns && v >= span / 2) v = v - span;
      return v[31:0];
   endfunction

   // One instruction through the main instance. wait_n = number of BUSY
   // cycles with dm_ready low before it goes high.
   task automatic txn(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                      input int wait_n);
      logic legal = m_legal(sz, a);
      int   stalls = 0;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
      req_addr = a; req_wdata = wd; dm_rdata = rd; dm_ready = 1'b0;
      #1;
      chk({tag, ".req_stall"}, stall, legal);
      chk({tag, ".req_dmreq"}, dm_req, 0);
      if (stall) stalls++;
      if (!legal) begin
         @(negedge clk); req_valid = 1'b0; #1;
         chk({tag, ".addr_err"}, addr_err, 1);
         chk({tag, ".err_dmreq"}, dm_req, 0);
         chk({tag, ".err_stall"}, stall, 0);
         @(negedge clk); #1;
         chk({tag, ".addr_err_clr"}, addr_err, 0);
         chk({tag, ".err_dmreq2"}, dm_req, 0);
         return;
      end
      for (int b = 0; b <= wait_n; b++) begin
         @(negedge clk); dm_ready = (b == wait_n); #1;
         chk({tag, ".dm_req"}, dm_req, 1);
         chk({tag, ".dm_we"}, dm_we, we);
         chk({tag, ".dm_be"}, dm_be, m_be(we, sz, a));
         chk({tag, ".dm_addr"}, dm_addr, a & 32'hFFFF_FFFC);
         chk({tag, ".dm_wdata"}, dm_wdata, m_wdata(we, sz, wd));
         chk({tag, ".busy_stall"}, stall, 1);
         if (stall) stalls++;
      end
      @(negedge clk); dm_ready = 1'b0; #1;
      chk({tag, ".done_stall"}, stall, 0);
      chk({tag, ".done_dmreq"}, dm_req, 0);
      chk({tag, ".rvalid"}, rdata_valid, !we);
      chk({tag, ".bus_err"}, bus_err, 0);
      if (!we) chk({tag, ".rdata"}, rdata_out, m_load(sz, uns, a, rd));
      chk({tag, ".stall_cycles"}, stalls, 2 + wait_n);
      req_valid = 1'b0;
      @(negedge clk); #1;
      chk({tag, ".rvalid_clr"}, rdata_valid, 0);
      chk({tag, ".idle_stall"}, stall, 0);
   endtask

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
      req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; dm_rdata = '0;
      dm_ready = 1'b0; req_valid_t = 1'b0; dm_ready_t = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst.stall", stall, 0);
      chk("rst.dm_req", dm_req, 0);
      chk("rst.dm_be", dm_be, 0);
      chk("rst.dm_addr", dm_addr, 0);
      chk("rst.dm_wdata", dm_wdata, 0);
      chk("rst.rdata_out", rdata_out, 0);
      chk("rst.flags", {rdata_valid, addr_err, bus_err, dm_we}, 0);
      @(negedge clk); reset = 1'b0;

      // Directed cases
      txn("sb",  1, SIZE_BYTE, 0, 32'h1003, 32'h1234_56AB, 32'h0, 0);
      txn("lb",  0, SIZE_BYTE, 0, 32'h2002, 32'h0, 32'h11F0_2233, 0);
      txn("lbu", 0, SIZE_BYTE, 1, 32'h2002, 32'h0, 32'h11F0_2233, 0);
      txn("lh",  0, SIZE_HALF, 0, 32'h2002, 32'h0, 32'h8001_2233, 0);
      txn("lhu", 0, SIZE_HALF, 1, 32'h2000, 32'h0, 32'h8001_2233, 0);
      txn("lw_mis", 0, SIZE_WORD, 0, 32'h2001, 32'h0, 32'h0, 0);
      txn("sh_mis", 1, SIZE_HALF, 0, 32'h3003, 32'h0, 32'h0, 0);
      txn("bad_sz", 0, 2'b11, 0, 32'h4000, 32'h0, 32'h0, 0);
      // dm_ready low through the request cycle and 4 BUSY cycles: 6 stalls
      txn("wait", 1, SIZE_WORD, 0, 32'h5004, 32'hCAFE_BABE, 32'h0, 4);

      // Randomized instructions
      for (int k = 0; k < 60; k++) begin
         txn("rnd", 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
             int'($urandom_range(0, 3)));
      end

      // Timeout on the TIMEOUT=3 instance, preceded by a good load so the
      // abort's zeroing of rdata_out is observable.
      @(negedge clk);
      req_valid_t = 1'b1; req_we = 1'b0; req_size = SIZE_WORD; req_unsigned = 1'b0;
      req_addr = 32'h0; dm_rdata = 32'hCAFE_F00D; dm_ready_t = 1'b1;
      @(negedge clk);
      @(negedge clk); req_valid_t = 1'b0; dm_ready_t = 1'b0; #1;
      chk("to.pre_rdata", t_rdata_out, 32'hCAFE_F00D);
      @(negedge clk);
      req_valid_t = 1'b1; #1;
      chk("to.req_stall", t_stall, 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         chk("to.busy_dmreq", t_dm_req, 1);
         chk("to.busy_stall", t_stall, 1);
         chk("to.busy_buserr", t_bus_err, 0);
      end
      @(negedge clk); #1;
      chk("to.bus_err", t_bus_err, 1);
      chk("to.dmreq_drop", t_dm_req, 0);
      chk("to.rvalid", t_rdata_valid, 0);
      chk("to.rdata_zero", t_rdata_out, 0);
      chk("to.done_stall", t_stall, 0);
      req_valid_t = 1'b0;
      @(negedge clk); #1;
      chk("to.bus_err_clr", t_bus_err, 0);

      // Reset during BUSY
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = SIZE_WORD; req_addr = 32'h40;
      dm_ready = 1'b0;
      @(negedge clk); #1;
      chk("rm.busy_dmreq", dm_req, 1);
      @(negedge clk); reset = 1'b1; req_valid = 1'b0;
      @(posedge clk); #1;
      chk("rm.dmreq", dm_req, 0);
      chk("rm.stall", stall, 0);
      chk("rm.pulses", {rdata_valid, addr_err, bus_err}, 0);
      @(negedge clk); reset = 1'b0;
      @(negedge clk); #1;
      chk("rm.idle", {dm_req, stall, rdata_valid, addr_err, bus_err}, 0);
      txn("rm.lw", 0, SIZE_WORD, 0, 32'h0, 32'h0, 32'hDEAD_BEEF, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_align_unit.md
Name: mem_align_unit

Overview:
- Memory-side load/store alignment unit for the pipelined MIPS core's M stage.
- Store path: narrows register data to byte/halfword lanes with byte enables.
- Load path: sign- or zero-extends the selected memory lane back to 32 bits.
- Sequences one data-memory transaction per instruction over a valid/ready handshake and stalls the pipeline until it completes.

Parameters:
- TIMEOUT, 255, max cycles to wait for dm_ready before aborting; 0 = wait forever.
- CNT_W, 8, width of the wait counter; must satisfy TIMEOUT < 2^CNT_W.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  M-stage instruction is a load or store.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  load extension: 1 = zero-extend (lbu/lhu), 0 = sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low byte/half used for sb/sh.
- stall  out  1  freeze pipeline registers.
- rdata_out  out  32  extended load result.
- rdata_valid  out  1  rdata_out valid (one cycle).
- addr_err  out  1  misaligned or illegal-size request (one cycle).
- bus_err  out  1  timeout abort (one cycle).
- dm_req  out  1  memory request valid.
- dm_we  out  1  memory write.
- dm_be  out  4  byte enables, bit i = byte lane i (little-endian).
- dm_addr  out  32  word address, bits [1:0] = 00.
- dm_wdata  out  32  lane-replicated write data.
- dm_ready  in  1  memory accepts/completes the request this cycle.
- dm_rdata  in  32  read word, valid when dm_ready = 1.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset values: state IDLE; wait counter 0; dm_req, dm_we, dm_be, dm_addr, dm_wdata, rdata_out, rdata_valid, addr_err and bus_err all 0. stall = 0.
- Reset during BUSY drops dm_req at that edge. The transaction is abandoned with no error pulse.

Legality check (combinational on req_* in IDLE):
- req_size = 11 is illegal.
- Half with addr[0] = 1 is misaligned.
- Word with addr[1:0] != 00 is misaligned.

FSM (states IDLE, BUSY, DONE):
- IDLE, req_valid = 1 and legal: register dm_we, dm_be, dm_addr, dm_wdata, size, unsigned flag and addr[1:0]. Go to BUSY with dm_req = 1 and counter cleared.
- IDLE, req_valid = 1 and illegal: no memory access, stay in IDLE. addr_err = 1 for the next cycle only.
- BUSY: hold all dm_* outputs stable.
  - On an edge with dm_ready = 1: drop dm_req and go to DONE. For a load, rdata_out <= extend(dm_rdata) and rdata_valid = 1 during DONE.
  - Otherwise the counter increments. If TIMEOUT != 0 and the counter reaches TIMEOUT: drop dm_req, go to DONE, bus_err = 1 during DONE, rdata_out = 0.
- DONE: ignore req_valid. Go to IDLE next edge; rdata_valid and bus_err return to 0.
- stall = (IDLE && req_valid && legal) || BUSY. It is 0 in DONE, so the pipeline advances at the end of DONE.

Store lane mapping:
- Byte: dm_be = 0001 << addr[1:0]; dm_wdata = {4{wdata[7:0]}}.
- Half: dm_be = addr[1] ? 1100 : 0011; dm_wdata = {2{wdata[15:0]}}.
- Word: dm_be = 1111; dm_wdata = wdata.

Load extraction:
- Byte: lane = dm_rdata[8*addr[1:0] +: 8].
- Half: lane = dm_rdata[16*addr[1] +: 16].
- Word: lane = dm_rdata (no extension).
- Extension: fill upper bits with 0 if unsigned, else with the lane MSB.
- For loads, dm_be = 1111 and dm_wdata = 0.

Minimum latency:
- Request cycle, then 1 BUSY cycle when dm_ready is already high, then DONE: 2 stall cycles.
- Each extra dm_ready-low cycle adds one stall cycle.

Decomposition:
- Shared package (mips_mem_pkg), constants:
  - SIZE_BYTE = 2'b00, SIZE_HALF = 2'b01, SIZE_WORD = 2'b10.
  - State encodings for IDLE/BUSY/DONE.
- One natural sub-module, load_extend: purely combinational lane select plus sign/zero extension. Inputs: rdata, addr[1:0], size, unsigned. Output: 32-bit result. It is reusable by the writeback stage.

Test Plan:
- sb: addr 0x1003, wdata 0x123456AB, dm_ready high -> dm_be 1000, dm_wdata 0xABABABAB, dm_addr 0x1000. stall high for exactly 2 cycles; no rdata_valid.
- lb/lbu: addr 0x2002, dm_rdata 0x11F02233 -> lb gives rdata_out 0xFFFFFFF0; lbu gives 0x000000F0. rdata_valid is one cycle.
- lh: addr 0x2002, dm_rdata 0x80012233 -> 0xFFFF8001. lhu at addr 0x2000 -> 0x00002233.
- Misaligned: lw at 0x2001 and sh at 0x3003 -> addr_err one cycle, dm_req never asserted, stall stays 0.
- Wait states: dm_ready low 5 cycles then high -> dm_req and dm_* stable throughout, stall 6 cycles. With TIMEOUT = 3 and dm_ready never high -> bus_err after 3 BUSY cycles, dm_req drops.
- Reset mid-op: assert reset during BUSY -> at that edge dm_req = 0 and state IDLE, no error or valid pulse. A following lw at 0x0 with dm_rdata 0xDEADBEEF returns 0xDEADBEEF.
